// File: rtl/p2s_stream.sv
`timescale 1ns/1ps
// p2s_stream: parallel-to-serial converter with valid/ready on both sides.
// Words are buffered in a small FIFO and shifted out one bit per accepted
// serial beat. ser_last flags the final bit of each word, and back-to-back
// words stream without an idle cycle between them.
module p2s_stream #(
  parameter int N         = 4,
  parameter int DEPTH     = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       par_valid,
  output logic                       par_ready,
  input  logic [N-1:0]               par_data,
  output logic                       ser_valid,
  input  logic                       ser_ready,
  output logic                       ser_data,
  output logic                       ser_last,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = ($clog2(N) > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic [0:0]    state;
  logic [N-1:0]  shift_reg;
  logic [CW-1:0] count;

  logic push;
  logic pop;
  logic beat;
  logic last_bit;

  // Handshake and pop decisions; par_ready depends on registered level only
  always_comb begin
    par_ready = (level_q != LW'(DEPTH));
    push      = par_valid && par_ready;
    beat      = (state == SHIFT) && ser_ready;
    last_bit  = (count == CW'(N-1));
    // Pop uses the registered level, so a same-cycle push is not visible here
    pop       = (level_q != '0) && ((state == IDLE) || (beat && last_bit));
  end

  // FIFO storage; contents need no reset since level gates every read
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= par_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Shifter FSM: load on pop, shift one bit per beat, return to IDLE when drained
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      shift_reg <= '0;
      count     <= '0;
    end else if (pop) begin
      state     <= SHIFT;
      shift_reg <= mem[rd_ptr];
      count     <= '0;
    end else if (beat) begin
      if (MSB_FIRST)
        shift_reg <= {shift_reg[N-2:0], 1'b0};
      else
        shift_reg <= {1'b0, shift_reg[N-1:1]};
      if (last_bit) begin
        state <= IDLE;
        count <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  // Serial outputs are forced low outside SHIFT so stale shifter bits never show
  always_comb begin
    ser_valid = (state == SHIFT);
    ser_data  = ser_valid && (MSB_FIRST ? shift_reg[N-1] : shift_reg[0]);
    ser_last  = ser_valid && last_bit;
    level     = level_q;
  end

endmodule
